cdb_arbiter: RTL
================

CDB_ARBITER -- requirements
Module: cdb_arbiter

Interface
REQ-001 Parameter: QWD, 2, log2 of per-source queue depth (DEPTH = 2^QWD = 4).
REQ-002 The block SHALL have one clock; reset is synchronous and active-high.
REQ-003 clk  in  1  clock; all state updates on posedge.
REQ-004 rst  in  1  synchronous active-high reset.
REQ-005 rdy  in  1  global enable; low = freeze all state, ignore inputs.
REQ-006 flush  in  1  mispredict clear, driven from jump_wrong_flag.
REQ-007 ex_in_flag / ex_in_rob_id / ex_in_val / ex_in_rel_pc  in  1/32/32/32  ALU result request.
REQ-008 ld_in_flag / ld_in_rob_id / ld_in_val  in  1/32/32  load result request.
REQ-009 ex_full / ld_full  out  1 each  combinational; high when that queue holds DEPTH entries.
REQ-010 cdb_flag / cdb_src / cdb_rob_id / cdb_val / cdb_rel_pc  out  1/1/32/32/32  registered broadcast; cdb_src 0=ALU, 1=load.

Function
REQ-011 The block SHALL hold one FIFO per source, DEPTH entries, with QWD-bit read/write pointers and a (QWD+1)-bit count.
REQ-012 The block SHALL push an entry when in_flag=1, rdy=1, flush=0, and the queue is not full; a push while full is dropped, even if a pop occurs in the same cycle.
REQ-013 Load entries SHALL store rel_pc = 0.
REQ-014 Each enabled, non-flush cycle, the block SHALL select at most one source among candidates, where a candidate is a non-empty queue, or an empty queue with in_flag=1 (bypass).
REQ-015 The winner's head, or its bypassed input, SHALL be registered onto cdb_* with cdb_flag=1, and the queue SHALL pop; with no candidate, cdb_flag<=0 and the data outputs hold.
REQ-016 Latency: a request into an empty queue SHALL appear on the CDB in the next cycle if it wins arbitration; otherwise it waits in the queue.
REQ-017 A bypassed winning input SHALL NOT be written into its queue.
REQ-018 A losing bypass input SHALL be pushed into its queue.
REQ-019 Simultaneous push and pop on one queue SHALL leave count unchanged, with both pointers advancing modulo DEPTH.
REQ-020 Per-source order SHALL be preserved (FIFO); no entry is duplicated or lost except by overflow drop or flush.
REQ-021 A last_grant register (0=ALU, 1=load) SHALL update to the winner on every grant.
REQ-022 flush=1 with rdy=1 SHALL clear both counts and pointers, force cdb_flag<=0, and discard same-cycle inputs.
REQ-023 last_grant SHALL be unchanged by flush.
REQ-024 rdy=0 SHALL hold every register, including cdb_flag and cdb_* (ROB samples only when rdy=1, so there is no double broadcast).
REQ-025 flush SHALL have priority over arbitration; rst SHALL have priority over flush and rdy.

Reset
REQ-026 On rst=1 at posedge, the block SHALL set cdb_flag=0, cdb_src=0, cdb_rob_id=0, cdb_val=0, cdb_rel_pc=0, all pointers and counts to 0, and last_grant=1, so the ALU wins first under round-robin.
REQ-027 Reset asserted mid-operation SHALL discard all queued entries in the same edge.
REQ-028 ex_full and ld_full SHALL be 0 from the cycle after reset.

Configuration
REQ-029 The macro CDB_ARB_RR_EN SHALL select the arbitration policy.
REQ-030 With CDB_ARB_RR_EN defined: when both sources are candidates, the source with source != last_grant SHALL win (round-robin).
REQ-031 Without CDB_ARB_RR_EN: the load SHALL always win over ALU, and last_grant SHALL still be maintained but unused.
REQ-032 A single candidate SHALL win under either policy.

Verification
REQ-033 Reset, then ex_in_flag=1, rob_id=5, val=0x11, rel_pc=0x100 for one cycle -> next cycle cdb_flag=1, src=0, rob_id=5, val=0x11, rel_pc=0x100; the following cycle cdb_flag=0.
REQ-034 RR build: ALU ids 1,2 and load ids 9,10 presented on consecutive cycles -> CDB order 1,9,2,10, one per cycle, then cdb_flag=0.
REQ-035 Fixed build, same stimulus -> CDB order 9,10,1,2.
REQ-036 Hold the load winning while pushing 5 ALU ids 1..5 -> ex_full=1 after the 4th queued entry, id 5 dropped; ALU later drains 1,2,3,4 only.
REQ-037 Queue 3 ALU and 2 load entries, assert flush for one cycle with a new ex_in_flag (id 7) -> cdb_flag=0 next cycle, counts 0, id 7 never broadcast.
REQ-038 While cdb_flag=1 with id 3, drop rdy for 4 cycles with input pulses -> outputs frozen at id 3, inputs ignored; resumes correctly when rdy=1.

Source files
------------

// File: rtl/cdb_arbiter_if.sv
// Bus bundle for the CDB arbiter: ALU and load result requests going in,
// queue-full back-pressure and the registered CDB broadcast coming out.
// master = request/broadcast consumer side, slave = the arbiter itself.
interface cdb_arbiter_if;
  logic        ex_in_flag;
  logic [31:0] ex_in_rob_id;
  logic [31:0] ex_in_val;
  logic [31:0] ex_in_rel_pc;
  logic        ld_in_flag;
  logic [31:0] ld_in_rob_id;
  logic [31:0] ld_in_val;
  logic        ex_full;
  logic        ld_full;
  logic        cdb_flag;
  logic        cdb_src;
  logic [31:0] cdb_rob_id;
  logic [31:0] cdb_val;
  logic [31:0] cdb_rel_pc;

  modport master (
    output ex_in_flag, ex_in_rob_id, ex_in_val, ex_in_rel_pc,
    output ld_in_flag, ld_in_rob_id, ld_in_val,
    input  ex_full, ld_full,
    input  cdb_flag, cdb_src, cdb_rob_id, cdb_val, cdb_rel_pc
  );

  modport slave (
    input  ex_in_flag, ex_in_rob_id, ex_in_val, ex_in_rel_pc,
    input  ld_in_flag, ld_in_rob_id, ld_in_val,
    output ex_full, ld_full,
    output cdb_flag, cdb_src, cdb_rob_id, cdb_val, cdb_rel_pc
  );
endinterface

// File: rtl/cdb_arbiter.sv
// Common data bus arbiter: one small FIFO per result source (0 = ALU,
// 1 = load), one broadcast per cycle onto a registered CDB. An empty queue
// whose request wins goes straight to the CDB without being stored.
// Arbitration policy: define CDB_ARB_RR_EN for round-robin between the two
// sources; by default the load source has fixed priority over the ALU.
module cdb_arbiter #(
  parameter int QWD = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         rdy,
  input  logic         flush,
  cdb_arbiter_if.slave bus
);

  localparam int DEPTH = 1 << QWD;
  localparam int NSRC  = 2;

  // Per-source request view, index 0 = ALU, index 1 = load.
  logic [NSRC-1:0]       in_flag;
  logic [NSRC-1:0][31:0] in_rob_id;
  logic [NSRC-1:0][31:0] in_val;
  logic [NSRC-1:0][31:0] in_rel_pc;

  assign in_flag   = {bus.ld_in_flag, bus.ex_in_flag};
  assign in_rob_id = {bus.ld_in_rob_id, bus.ex_in_rob_id};
  assign in_val    = {bus.ld_in_val, bus.ex_in_val};
  // Loads carry no PC; their entries always hold zero there.
  assign in_rel_pc = {32'd0, bus.ex_in_rel_pc};

  logic                  active;
  logic [NSRC-1:0]       q_empty;
  logic [NSRC-1:0]       q_full;
  logic [NSRC-1:0]       cand;
  logic [NSRC-1:0]       grant;
  logic [NSRC-1:0]       bypass;
  logic [NSRC-1:0]       push;
  logic [NSRC-1:0]       pop;
  logic [NSRC-1:0][31:0] head_rob_id;
  logic [NSRC-1:0][31:0] head_val;
  logic [NSRC-1:0][31:0] head_rel_pc;

  logic                  any_cand;
  logic                  win_src;
  logic                  last_grant_reg;

  logic                  cdb_flag_reg;
  logic                  cdb_src_reg;
  logic [31:0]           cdb_rob_id_reg;
  logic [31:0]           cdb_val_reg;
  logic [31:0]           cdb_rel_pc_reg;

  // Nothing moves unless the pipeline is enabled and not being flushed.
  assign active = rdy && !flush;

  genvar gi;
  generate
    for (gi = 0; gi < NSRC; gi++) begin : g_queue
      logic [31:0]    mem_rob_id [DEPTH];
      logic [31:0]    mem_val    [DEPTH];
      logic [31:0]    mem_rel_pc [DEPTH];
      logic [QWD-1:0] wptr_reg;
      logic [QWD-1:0] rptr_reg;
      logic [QWD:0]   count_reg;

      assign q_empty[gi] = (count_reg == '0);
      assign q_full[gi]  = (count_reg == (QWD+1)'(DEPTH));

      // A source competes when it has a queued entry or a live request.
      assign cand[gi]   = !q_empty[gi] || in_flag[gi];
      assign bypass[gi] = grant[gi] && q_empty[gi];
      assign pop[gi]    = grant[gi] && !q_empty[gi];
      // Full is judged before any same-cycle pop, so a push into a full
      // queue is dropped even while the head is leaving.
      assign push[gi]   = active && in_flag[gi] && !q_full[gi] && !bypass[gi];

      // The head seen by the arbiter is the live input when the queue is empty.
      assign head_rob_id[gi] = q_empty[gi] ? in_rob_id[gi] : mem_rob_id[rptr_reg];
      assign head_val[gi]    = q_empty[gi] ? in_val[gi]    : mem_val[rptr_reg];
      assign head_rel_pc[gi] = q_empty[gi] ? in_rel_pc[gi] : mem_rel_pc[rptr_reg];

      // Entry storage: write the incoming request at the tail.
      always_ff @(posedge clk) begin
        if (push[gi]) begin
          mem_rob_id[wptr_reg] <= in_rob_id[gi];
          mem_val[wptr_reg]    <= in_val[gi];
          mem_rel_pc[wptr_reg] <= in_rel_pc[gi];
        end
      end

      // Queue bookkeeping: pointers wrap naturally at DEPTH, count tracks fill.
      always_ff @(posedge clk) begin
        if (rst) begin
          wptr_reg  <= '0;
          rptr_reg  <= '0;
          count_reg <= '0;
        end else if (rdy) begin
          if (flush) begin
            wptr_reg  <= '0;
            rptr_reg  <= '0;
            count_reg <= '0;
          end else begin
            wptr_reg  <= wptr_reg + QWD'(push[gi]);
            rptr_reg  <= rptr_reg + QWD'(pop[gi]);
            count_reg <= count_reg + (QWD+1)'(push[gi]) - (QWD+1)'(pop[gi]);
          end
        end
      end
    end
  endgenerate

  // Pick at most one source per cycle.
  always_comb begin
    any_cand = |cand;
    win_src  = 1'b0;
    if (&cand) begin
`ifdef CDB_ARB_RR_EN
      win_src = ~last_grant_reg;
`else
      win_src = 1'b1;
`endif
    end else begin
      win_src = cand[1];
    end
    grant = '0;
    if (active && any_cand) begin
      grant[win_src] = 1'b1;
    end
  end

`ifndef CDB_ARB_RR_EN
  // last_grant is still kept up to date with fixed priority; this tap keeps
  // it from looking like dead logic.
  logic last_grant_unused;
  assign last_grant_unused = last_grant_reg;
`endif

  // Registered broadcast and grant history.
  always_ff @(posedge clk) begin
    if (rst) begin
      cdb_flag_reg   <= 1'b0;
      cdb_src_reg    <= 1'b0;
      cdb_rob_id_reg <= '0;
      cdb_val_reg    <= '0;
      cdb_rel_pc_reg <= '0;
      last_grant_reg <= 1'b1;
    end else if (rdy) begin
      if (flush) begin
        cdb_flag_reg <= 1'b0;
      end else if (any_cand) begin
        cdb_flag_reg   <= 1'b1;
        cdb_src_reg    <= win_src;
        cdb_rob_id_reg <= head_rob_id[win_src];
        cdb_val_reg    <= head_val[win_src];
        cdb_rel_pc_reg <= head_rel_pc[win_src];
        last_grant_reg <= win_src;
      end else begin
        cdb_flag_reg <= 1'b0;
      end
    end
  end

  assign bus.ex_full    = q_full[0];
  assign bus.ld_full    = q_full[1];
  assign bus.cdb_flag   = cdb_flag_reg;
  assign bus.cdb_src    = cdb_src_reg;
  assign bus.cdb_rob_id = cdb_rob_id_reg;
  assign bus.cdb_val    = cdb_val_reg;
  assign bus.cdb_rel_pc = cdb_rel_pc_reg;

endmodule
